// File: rtl/cmd_dispatch_fsm_pkg.sv
// Shared opcodes, state encodings and helpers for the command-dispatch controller.
package cmd_dispatch_fsm_pkg;

    localparam logic [2:0] OP_STP = 3'd0;
    localparam logic [2:0] OP_EVP = 3'd1;
    localparam logic [2:0] OP_EVB = 3'd2;
    localparam logic [2:0] OP_RST = 3'd3;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned START_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_LAUNCH = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    // Ceiling log2 with a floor of 1, so a depth of 1 still gets a 1-bit address.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned r;
        r = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cmd_ptr_wrap.sv
// Command-FIFO read pointer: increments with wrap at DEPTH-1, synchronous clear wins.
module cmd_ptr_wrap #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inc,
    input  logic          i_clr,
    output logic [AW-1:0] o_ptr
);

    logic [AW-1:0] r_ptr;

    // Pointer register; clear has priority so a reset command overrides the decode increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/cmd_dispatch_fsm.sv
// Command dispatcher: fetches, decodes and launches one sub-FSM at a time.
module cmd_dispatch_fsm
    import cmd_dispatch_fsm_pkg::*;
#(
    parameter  int unsigned BUFFER_SIZE = 1024,
    parameter  int unsigned WORD_SIZE   = 16,
    localparam int unsigned AW          = log2(BUFFER_SIZE),
    localparam int unsigned ARG_W       = WORD_SIZE - 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [AW:0]          cmd_population,
    input  logic [WORD_SIZE-1:0] cmd_rd_data,
    output logic [AW-1:0]        cmd_rd_addr,
    output logic                 cmd_pop,
    output logic [ARG_W-1:0]     cmd_arg,
    output logic                 start_stp,
    output logic                 start_evp,
    output logic                 start_evb,
    output logic                 start_rst,
    input  logic                 done_stp,
    input  logic                 done_evp,
    input  logic                 done_evb,
    input  logic                 done_rst,
    output logic                 busy,
    output logic                 err_invalid,
    output logic [7:0]           invalid_count
);

    state_t               r_state;
    state_t               w_next_state;
    logic [OP_W-1:0]      r_op;
    logic [OP_W-1:0]      w_op_nxt;
    logic [ARG_W-1:0]     r_arg;
    logic [ARG_W-1:0]     w_arg_nxt;
    logic [7:0]           r_invalid_cnt;
    logic [7:0]           w_invalid_cnt_nxt;
    logic [START_W-1:0]   r_start;
    logic [START_W-1:0]   w_start_nxt;
    logic                 r_err;
    logic                 w_err_nxt;
    logic                 r_pop;
    logic                 r_busy;
    logic                 w_done_hit;
    logic                 w_ptr_inc;
    logic                 w_ptr_clr;
    logic [AW-1:0]        w_ptr;

    cmd_ptr_wrap #(
        .DEPTH (BUFFER_SIZE),
        .AW    (AW)
    ) u_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_ptr_inc),
        .i_clr (w_ptr_clr),
        .o_ptr (w_ptr)
    );

    // Next-state, decode and side-effect selection.
    always_comb begin
        w_next_state      = r_state;
        w_op_nxt          = r_op;
        w_arg_nxt         = r_arg;
        w_invalid_cnt_nxt = r_invalid_cnt;
        w_start_nxt       = '0;
        w_err_nxt         = 1'b0;
        w_ptr_inc         = 1'b0;
        w_ptr_clr         = 1'b0;
        w_done_hit        = 1'b0;

        // Only the done of the launched sub-FSM matters.
        case (r_op)
            OP_STP:  w_done_hit = done_stp;
            OP_EVP:  w_done_hit = done_evp;
            OP_EVB:  w_done_hit = done_evb;
            OP_RST:  w_done_hit = done_rst;
            default: w_done_hit = 1'b0;
        endcase

        unique case (r_state)
            S_IDLE: begin
                if (cmd_population != '0) begin
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_op_nxt  = cmd_rd_data[OP_W-1:0];
                w_arg_nxt = cmd_rd_data[WORD_SIZE-1:OP_W];
                w_ptr_inc = 1'b1;
                case (cmd_rd_data[OP_W-1:0])
                    OP_STP: begin w_start_nxt = 4'b0001; w_next_state = S_LAUNCH; end
                    OP_EVP: begin w_start_nxt = 4'b0010; w_next_state = S_LAUNCH; end
                    OP_EVB: begin w_start_nxt = 4'b0100; w_next_state = S_LAUNCH; end
                    OP_RST: begin w_start_nxt = 4'b1000; w_next_state = S_LAUNCH; end
                    default: begin
                        w_err_nxt         = 1'b1;
                        w_invalid_cnt_nxt = (r_invalid_cnt == 8'hFF) ? r_invalid_cnt
                                                                     : r_invalid_cnt + 8'd1;
                        w_next_state      = S_IDLE;
                    end
                endcase
            end
            S_LAUNCH: begin
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (w_done_hit) begin
                    w_next_state = S_IDLE;
                    w_ptr_clr    = (r_op == OP_RST);
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Registered datapath and outputs; pop is high while in DECODE so the FIFO
    // has decremented before IDLE next samples the population.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op          <= '0;
            r_arg         <= '0;
            r_invalid_cnt <= '0;
            r_start       <= '0;
            r_err         <= 1'b0;
            r_pop         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_op          <= w_op_nxt;
            r_arg         <= w_arg_nxt;
            r_invalid_cnt <= w_invalid_cnt_nxt;
            r_start       <= w_start_nxt;
            r_err         <= w_err_nxt;
            r_pop         <= (w_next_state == S_DECODE);
            r_busy        <= (w_next_state != S_IDLE);
        end
    end

    assign cmd_rd_addr   = w_ptr;
    assign cmd_pop       = r_pop;
    assign cmd_arg       = r_arg;
    assign start_stp     = r_start[0];
    assign start_evp     = r_start[1];
    assign start_evb     = r_start[2];
    assign start_rst     = r_start[3];
    assign busy          = r_busy;
    assign err_invalid   = r_err;
    assign invalid_count = r_invalid_cnt;

endmodule

// File: tb/tb_cmd_dispatch_fsm.sv
// Directed self-checking bench for cmd_dispatch_fsm (16-deep FIFO instance).
module tb_cmd_dispatch_fsm;

    localparam int unsigned BUF = 16;
    localparam int unsigned AW  = 4;
    localparam int unsigned WS  = 16;

    logic              clk;
    logic              rst;
    logic [AW:0]       cmd_population;
    logic [WS-1:0]     cmd_rd_data;
    logic [AW-1:0]     cmd_rd_addr;
    logic              cmd_pop;
    logic [WS-4:0]     cmd_arg;
    logic              start_stp, start_evp, start_evb, start_rst;
    logic              done_stp, done_evp, done_evb, done_rst;
    logic              busy;
    logic              err_invalid;
    logic [7:0]        invalid_count;

    logic [WS-1:0]     ram [BUF];
    int                push_total = 0;
    int                pop_total  = 0;
    int                n_pass;
    int                n_chk;

    wire  [3:0]        starts = {start_rst, start_evb, start_evp, start_stp};

    cmd_dispatch_fsm #(
        .BUFFER_SIZE (BUF),
        .WORD_SIZE   (WS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_population (cmd_population),
        .cmd_rd_data    (cmd_rd_data),
        .cmd_rd_addr    (cmd_rd_addr),
        .cmd_pop        (cmd_pop),
        .cmd_arg        (cmd_arg),
        .start_stp      (start_stp),
        .start_evp      (start_evp),
        .start_evb      (start_evb),
        .start_rst      (start_rst),
        .done_stp       (done_stp),
        .done_evp       (done_evp),
        .done_evb       (done_evb),
        .done_rst       (done_rst),
        .busy           (busy),
        .err_invalid    (err_invalid),
        .invalid_count  (invalid_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Command RAM with one cycle of read latency.
    always @(posedge clk) cmd_rd_data <= ram[cmd_rd_addr];

    // FIFO population model: pushes from the tests, pops from the DUT.
    always @(posedge clk) if (cmd_pop) pop_total <= pop_total + 1;
    assign cmd_population = (AW + 1)'(push_total - pop_total);

    // Waits for a launch, then answers with the matching done dly cycles later.
    task automatic serve_cmd(input int dly, output logic [3:0] seen, output int n_hi, output bit to);
        seen = '0;
        n_hi = 0;
        to   = 1'b1;
        for (int k = 0; k < 20 && to; k++) begin
            @(negedge clk);
            if (starts != 4'b0000) begin
                seen = starts;
                n_hi = 1;
                to   = 1'b0;
            end
        end
        if (!to) begin
            for (int j = 1; j <= dly; j++) begin
                @(negedge clk);
                if (starts != 4'b0000) n_hi++;
                seen = seen | starts;
                if (j == dly) begin
                    done_stp = seen[0];
                    done_evp = seen[1];
                    done_evb = seen[2];
                    done_rst = seen[3];
                end
            end
            @(negedge clk);
            done_stp = 1'b0;
            done_evp = 1'b0;
            done_evb = 1'b0;
            done_rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        int busy_hi;
        int st_hi;
        busy_hi = 0;
        st_hi   = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, cmd_pop, err_invalid, starts} !== 7'b0) $display("FAIL reset_ctrl: got %b expected 0000000", {busy, cmd_pop, err_invalid, starts});
        else n_pass++;
        n_chk++;
        if ({cmd_rd_addr, cmd_arg, invalid_count} !== '0) $display("FAIL reset_regs: got addr=%0d arg=%0d cnt=%0d expected all 0", cmd_rd_addr, cmd_arg, invalid_count);
        else n_pass++;
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (busy) busy_hi++;
            if (starts != 4'b0000) st_hi++;
        end
        n_chk++;
        if (busy_hi !== 0) $display("FAIL idle_busy: got %0d busy cycles expected 0", busy_hi);
        else n_pass++;
        n_chk++;
        if (st_hi !== 0) $display("FAIL idle_start: got %0d start cycles expected 0", st_hi);
        else n_pass++;
        n_chk++;
        if (cmd_rd_addr !== 4'd0) $display("FAIL idle_addr: got %0d expected 0", cmd_rd_addr);
        else n_pass++;
    endtask

    task automatic test_evp();
        int start_cyc, evp_hi, pops, others;
        logic busy_d, busy_a;
        start_cyc = 0; evp_hi = 0; pops = 0; others = 0;
        busy_d = 1'bx; busy_a = 1'bx;
        ram[0] = 16'h0029;
        push_total = push_total + 1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            done_evp = 1'b0;
            if (start_evp) begin
                evp_hi++;
                if (start_cyc == 0) start_cyc = k;
            end
            if (cmd_pop) pops++;
            if (start_stp || start_evb || start_rst) others++;
            if (start_cyc != 0 && k == start_cyc + 3) begin
                done_evp = 1'b1;
                busy_d   = busy;
            end
            if (start_cyc != 0 && k == start_cyc + 4) busy_a = busy;
        end
        done_evp = 1'b0;
        n_chk++;
        if (start_cyc !== 3) $display("FAIL evp_latency: got cycle %0d expected 3", start_cyc);
        else n_pass++;
        n_chk++;
        if (evp_hi !== 1) $display("FAIL evp_pulse: got %0d cycles expected 1", evp_hi);
        else n_pass++;
        n_chk++;
        if (others !== 0) $display("FAIL evp_other_start: got %0d expected 0", others);
        else n_pass++;
        n_chk++;
        if (pops !== 1) $display("FAIL evp_pop: got %0d pops expected 1", pops);
        else n_pass++;
        n_chk++;
        if (cmd_arg !== 13'd5) $display("FAIL evp_arg: got %0d expected 5", cmd_arg);
        else n_pass++;
        n_chk++;
        if (cmd_rd_addr !== 4'd1) $display("FAIL evp_addr: got %0d expected 1", cmd_rd_addr);
        else n_pass++;
        n_chk++;
        if ({busy_d, busy_a} !== 2'b10) $display("FAIL evp_busy_fall: got %b expected 10", {busy_d, busy_a});
        else n_pass++;
    endtask

    task automatic test_rst_cmd();
        logic [3:0] seen;
        int n_hi;
        bit to;
        ram[1] = 16'h0038;
        ram[2] = 16'h0012;
        ram[3] = 16'h0003;
        push_total = push_total + 1;
        serve_cmd(1, seen, n_hi, to);
        n_chk++;
        if ({to, seen} !== 5'b0_0001 || cmd_arg !== 13'd7) $display("FAIL stp_cmd: got to=%0d seen=%b arg=%0d expected 0 0001 7", to, seen, cmd_arg);
        else n_pass++;
        push_total = push_total + 1;
        serve_cmd(1, seen, n_hi, to);
        n_chk++;
        if ({to, seen} !== 5'b0_0100 || cmd_arg !== 13'd2) $display("FAIL evb_cmd: got to=%0d seen=%b arg=%0d expected 0 0100 2", to, seen, cmd_arg);
        else n_pass++;
        n_chk++;
        if (cmd_rd_addr !== 4'd3) $display("FAIL pre_rst_addr: got %0d expected 3", cmd_rd_addr);
        else n_pass++;
        push_total = push_total + 1;
        serve_cmd(2, seen, n_hi, to);
        n_chk++;
        if ({to, seen} !== 5'b0_1000 || n_hi !== 1) $display("FAIL rst_start: got to=%0d seen=%b pulses=%0d expected 0 1000 1", to, seen, n_hi);
        else n_pass++;
        n_chk++;
        if (cmd_rd_addr !== 4'd0 || busy !== 1'b0) $display("FAIL rst_addr_clear: got addr=%0d busy=%b expected 0 0", cmd_rd_addr, busy);
        else n_pass++;
    endtask

    task automatic test_invalid_wrap();
        logic [3:0] seen;
        int n_hi, err_hi, st_hi;
        bit to;
        err_hi = 0;
        st_hi  = 0;
        for (int i = 0; i < 15; i++) ram[i] = 16'h0000;
        for (int i = 0; i < 15; i++) begin
            push_total = push_total + 1;
            serve_cmd(1, seen, n_hi, to);
        end
        n_chk++;
        if (cmd_rd_addr !== 4'd15) $display("FAIL wrap_pre_addr: got %0d expected 15", cmd_rd_addr);
        else n_pass++;
        ram[15] = 16'h0006;
        push_total = push_total + 1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (err_invalid) err_hi++;
            if (starts != 4'b0000) st_hi++;
        end
        n_chk++;
        if (err_hi !== 1) $display("FAIL err_pulse: got %0d cycles expected 1", err_hi);
        else n_pass++;
        n_chk++;
        if (st_hi !== 0) $display("FAIL err_no_start: got %0d expected 0", st_hi);
        else n_pass++;
        n_chk++;
        if (invalid_count !== 8'd1) $display("FAIL err_count: got %0d expected 1", invalid_count);
        else n_pass++;
        n_chk++;
        if (cmd_rd_addr !== 4'd0 || busy !== 1'b0) $display("FAIL wrap_addr: got addr=%0d busy=%b expected 0 0", cmd_rd_addr, busy);
        else n_pass++;
    endtask

    task automatic test_saturate();
        int err_hi;
        err_hi = 0;
        for (int i = 0; i < 16; i++) ram[i] = 16'h0007;
        for (int i = 0; i < 256; i++) begin
            push_total = push_total + 1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                if (i == 255 && err_invalid) err_hi++;
            end
            if (i == 252) begin
                n_chk++;
                if (invalid_count !== 8'd254) $display("FAIL sat_mid: got %0d expected 254", invalid_count);
                else n_pass++;
            end
        end
        n_chk++;
        if (invalid_count !== 8'd255) $display("FAIL sat_hold: got %0d expected 255", invalid_count);
        else n_pass++;
        n_chk++;
        if (err_hi !== 1) $display("FAIL sat_err_pulse: got %0d expected 1", err_hi);
        else n_pass++;
    endtask

    task automatic test_stray_done_and_reset();
        bit to;
        to = 1'b1;
        ram[0] = 16'h0009;
        push_total = push_total + 1;
        for (int k = 0; k < 10 && to; k++) begin
            @(negedge clk);
            if (start_evp) to = 1'b0;
        end
        // done_evp coincides with LAUNCH and must be forgotten.
        done_evp = 1'b1;
        @(negedge clk);
        done_evp = 1'b0;
        done_stp = 1'b1;
        done_evb = 1'b1;
        done_rst = 1'b1;
        @(negedge clk);
        done_stp = 1'b0;
        done_evb = 1'b0;
        done_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({to, busy, starts} !== 6'b01_0000) $display("FAIL stray_done_wait: got to=%0d busy=%b starts=%b expected 0 1 0000", to, busy, starts);
        else n_pass++;
        n_chk++;
        if (cmd_rd_addr !== 4'd1 || cmd_arg !== 13'd1) $display("FAIL stray_done_regs: got addr=%0d arg=%0d expected 1 1", cmd_rd_addr, cmd_arg);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_chk++;
        if ({busy, cmd_pop, err_invalid, starts} !== 7'b0) $display("FAIL async_rst_ctrl: got %b expected 0000000", {busy, cmd_pop, err_invalid, starts});
        else n_pass++;
        n_chk++;
        if ({cmd_rd_addr, cmd_arg, invalid_count} !== '0) $display("FAIL async_rst_regs: got addr=%0d arg=%0d cnt=%0d expected all 0", cmd_rd_addr, cmd_arg, invalid_count);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL post_rst_idle: got busy=%b expected 0", busy);
        else n_pass++;
    endtask

    initial begin
        rst      = 1'b0;
        done_stp = 1'b0;
        done_evp = 1'b0;
        done_evb = 1'b0;
        done_rst = 1'b0;
        n_pass   = 0;
        n_chk    = 0;
        for (int i = 0; i < 16; i++) ram[i] = 16'h0000;
        test_reset();
        test_evp();
        test_rst_cmd();
        test_invalid_wrap();
        test_saturate();
        test_stray_done_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule

// File: doc/cmd_dispatch_fsm.md
Name: cmd_dispatch_fsm

Overview:
- Command-dispatch controller sitting directly upstream of the reset FSM in the polynomial evaluation accelerator.
- Owns the command-FIFO read pointer. Fetches one command word at a time from the command RAM and decodes the opcode.
- Launches exactly one sub-FSM (store-polynomial, evaluate, evaluate-block or reset) with a one-cycle start pulse, then waits for that FSM's done before fetching the next command.
- On completion of a reset command, reloads its read pointer to 0, matching the reset FSM's zeroed updated address.

Parameters:
- buffer_size, 1024: depth of the command FIFO RAM. Address width is log2(buffer_size), using the codebase log2 function (log2(1)=1).
- word_size, 16: command word width. Opcode occupies bits [2:0]; argument occupies bits [word_size-1:3].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- cmd_population  in  log2(buffer_size)+1  number of unread words in the command FIFO.
- cmd_rd_data  in  word_size  command RAM read data, valid one cycle after cmd_rd_addr is presented.
- cmd_rd_addr  out  log2(buffer_size)  command RAM read address (internal register).
- cmd_pop  out  1  one-cycle pulse; upstream FIFO decrements its population.
- cmd_arg  out  word_size-3  latched argument field.
- start_stp, start_evp, start_evb, start_rst  out  1 each  one-cycle launch pulses.
- done_stp, done_evp, done_evb, done_rst  in  1 each  completion from the corresponding sub-FSM.
- busy  out  1  high in every state except IDLE.
- err_invalid  out  1  one-cycle pulse on an undefined opcode.
- invalid_count  out  8  saturating count of undefined opcodes.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; cmd_rd_addr=0; cmd_arg=0; op register=0; invalid_count=0; all start_* =0; cmd_pop=0; err_invalid=0; busy=0.
- Opcodes: 0=STP, 1=EVP, 2=EVB, 3=RST, 4..7 invalid.
- States:
  - IDLE: if cmd_population != 0, go to FETCH; otherwise stay.
  - FETCH: cmd_rd_addr is already driven; wait one cycle for RAM latency; go to DECODE.
  - DECODE:
    - Latch cmd_rd_data[2:0] into op and cmd_rd_data[word_size-1:3] into cmd_arg.
    - Pulse cmd_pop.
    - cmd_rd_addr <= cmd_rd_addr+1, wrapping from buffer_size-1 to 0.
    - Valid opcode: go to LAUNCH.
    - Invalid opcode: pulse err_invalid, increment invalid_count (saturating at 255), go to IDLE. The command is consumed and discarded.
  - LAUNCH: assert the start_* matching op for exactly this cycle; go to WAIT.
  - WAIT:
    - Only the done_* matching op is sampled; done on other FSMs is ignored.
    - On the matching done, return to IDLE.
    - If op=RST, also set cmd_rd_addr <= 0 in that same cycle; this overrides the DECODE increment.
- done_* asserted during IDLE, FETCH, DECODE or LAUNCH is ignored. A done coinciding with LAUNCH is not remembered.
- All outputs are registered or decoded from state; no output depends combinationally on done_*.
- Minimum command period: 5 cycles (IDLE, FETCH, DECODE, LAUNCH, WAIT with done arriving in the first WAIT cycle).
- cmd_arg and op stay stable from DECODE until the next DECODE.
- cmd_population is sampled only in IDLE. A population drop during FETCH (e.g. external FIFO clear) does not abort the fetch.
- No timeout: WAIT holds indefinitely. Asynchronous reset is the only exit.
- Reset mid-operation: any state returns to IDLE immediately and in-flight start pulses drop. Sub-FSMs share the same reset.

Decomposition:
- Shared package/header holds:
  - opcode constants OP_STP=3'd0, OP_EVP=3'd1, OP_EVB=3'd2, OP_RST=3'd3;
  - state encodings S_IDLE..S_WAIT (3 bits);
  - the common log2 function.
- One natural sub-module: cmd_ptr_wrap, the read-pointer register with increment-with-wrap and synchronous clear.
- Everything else stays in the single FSM module.

Test Plan:
- Reset then population=0 for 20 cycles -> busy=0; no start_*; cmd_rd_addr=0.
- Population=1, RAM[0]=16'h0029 (op 1, arg 5), done_evp 3 cycles after start_evp -> start_evp high exactly 1 cycle, 2 cycles after population rises; cmd_arg=5; cmd_pop once; cmd_rd_addr=1; busy falls the cycle after done.
- RAM[3]=16'h0003 (RST) with cmd_rd_addr=3, reset FSM model returns done_rst 2 cycles after start_rst -> start_rst pulses once; cmd_rd_addr=0 after done_rst.
- Opcode 6 at address buffer_size-1 -> err_invalid 1-cycle pulse; invalid_count increments by 1; no start_*; cmd_rd_addr wraps to 0.
- 256 consecutive invalid opcodes -> invalid_count holds at 255.
- During WAIT for EVP, pulse done_stp and done_rst -> FSM stays in WAIT. Assert rst=0 mid-WAIT -> immediate IDLE with all outputs at reset values.
